// File: rtl/seven_seg_scan_driver_if.sv
// Digit/mode/alarm inputs from the clock core and the multiplexed display pins.
// The master side is the clock core; the slave side is the scan driver.
interface seven_seg_scan_driver_if #(
    parameter int unsigned DWL = 8
);
    logic [DWL-5:0] Hours_MSB;
    logic [DWL-5:0] Hours_LSB;
    logic [DWL-5:0] Minutes_MSB;
    logic [DWL-5:0] Minutes_LSB;
    logic [DWL-7:0] Mode;
    logic           ALARM;
    logic [3:0]     AN;
    logic [6:0]     SEG;
    logic           DP;

    modport master (
        output Hours_MSB, Hours_LSB, Minutes_MSB, Minutes_LSB, Mode, ALARM,
        input  AN, SEG, DP
    );

    modport slave (
        input  Hours_MSB, Hours_LSB, Minutes_MSB, Minutes_LSB, Mode, ALARM,
        output AN, SEG, DP
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame digit
// snapshot, anti-ghost dead time, colon blink and alarm flash.
module seven_seg_scan_driver #(
    parameter int unsigned DWL          = 8,
    parameter int unsigned REFRESH_DIV  = 49_999,
    parameter int unsigned DEAD_CYC     = 500,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic                    CLK,
    input  logic                    CLR_N,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int unsigned DigW  = DWL - 4;
    localparam int unsigned ModeW = DWL - 6;
    localparam int unsigned RcW   = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;
    localparam int unsigned FcW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [RcW-1:0]        r_rc;
    logic [1:0]            r_idx;
    logic [3:0][DigW-1:0]  r_snap;
    logic [ModeW-1:0]      r_mode;
    logic [FcW-1:0]        r_fc;
    logic                  r_blink;
    logic [3:0]            r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic                  w_rc_wrap;
    logic                  w_frame_end;
    logic                  w_fc_wrap;
    logic [DigW-1:0]       w_digit;
    logic [6:0]            w_dec;
    logic                  w_blank;
    logic                  w_dark;
    logic                  w_steady;
    logic [3:0]            w_an;
    logic [6:0]            w_seg;
    logic                  w_dp;

    assign w_rc_wrap   = (r_rc == RcW'(REFRESH_DIV));
    assign w_frame_end = w_rc_wrap && (r_idx == 2'd3);
    assign w_fc_wrap   = (r_fc == FcW'(BLINK_FRAMES - 1));
    assign w_digit     = r_snap[r_idx];

    always_comb begin
        w_dec = 7'h3F;
        case (w_digit[3:0])
            4'd0:    w_dec = 7'h40;
            4'd1:    w_dec = 7'h79;
            4'd2:    w_dec = 7'h24;
            4'd3:    w_dec = 7'h30;
            4'd4:    w_dec = 7'h19;
            4'd5:    w_dec = 7'h12;
            4'd6:    w_dec = 7'h02;
            4'd7:    w_dec = 7'h78;
            4'd8:    w_dec = 7'h00;
            4'd9:    w_dec = 7'h10;
            default: w_dec = 7'h3F;
        endcase
    end

    // Alarm flash reuses the colon blink phase so the whole display follows it.
    always_comb begin
        w_blank  = (32'(r_rc) < DEAD_CYC) || (bus.ALARM && !r_blink);
        w_dark   = (r_idx == 2'd3) && (r_snap[3] == '0);
        w_steady = (r_mode == ModeW'(1)) || (r_mode == ModeW'(2));
        w_an     = 4'hF;
        w_seg    = 7'h7F;
        w_dp     = 1'b1;
        if (!w_blank) begin
            if (!w_dark) begin
                w_an  = ~(4'b0001 << r_idx);
                w_seg = w_dec;
            end
            if (r_idx == 2'd2) begin
                w_dp = w_steady ? 1'b0 : ~r_blink;
            end else if ((r_idx == 2'd0) && (r_mode == ModeW'(2))) begin
                w_dp = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_rc    <= '0;
            r_idx   <= 2'd0;
            r_snap  <= '0;
            r_mode  <= '0;
            r_fc    <= '0;
            r_blink <= 1'b1;
            r_an    <= 4'hF;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
        end else begin
            if (w_rc_wrap) begin
                r_rc  <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_rc  <= r_rc + 1'b1;
            end
            // Snapshot on the last edge of a frame so a frame never mixes old and new digits.
            if (w_frame_end) begin
                r_snap <= {bus.Hours_MSB, bus.Hours_LSB, bus.Minutes_MSB, bus.Minutes_LSB};
                r_mode <= bus.Mode;
                if (w_fc_wrap) begin
                    r_fc    <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_fc    <= r_fc + 1'b1;
                end
            end
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign bus.AN  = r_an;
    assign bus.SEG = r_seg;
    assign bus.DP  = r_dp;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench comparing the scan driver against a cycle-count based
// reference model of the display timing.
module tb_seven_seg_scan_driver;
    localparam int unsigned DWL = 8;
    localparam int unsigned R   = 3;
    localparam int unsigned DC  = 1;
    localparam int unsigned BF  = 2;
    localparam int unsigned SLOT  = R + 1;
    localparam int unsigned FRAME = 4 * SLOT;

    logic clk;
    logic clr_n;

    seven_seg_scan_driver_if #(.DWL(DWL)) bus ();

    seven_seg_scan_driver #(
        .DWL(DWL), .REFRESH_DIV(R), .DEAD_CYC(DC), .BLINK_FRAMES(BF)
    ) dut (
        .CLK   (clk),
        .CLR_N (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state: cycles since reset release plus the digits shown this frame.
    int unsigned m_k;
    logic [3:0]  m_snap [4];
    logic [1:0]  m_mode;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d > 4'd9) ? 7'h3F : tab[d];
    endfunction

    task automatic model_reset();
        m_k = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
        m_mode = 2'd0;
    endtask

    // Outputs after this edge follow the state before it; then the frame may roll.
    task automatic model_step();
        int unsigned rc, slot, idx, frame;
        bit phase, blank, dark, steady;
        rc    = m_k % SLOT;
        slot  = m_k / SLOT;
        idx   = slot % 4;
        frame = slot / 4;
        phase = ((frame / BF) % 2) == 0;
        blank = (rc < DC) || (bus.ALARM && !phase);
        dark  = (idx == 3) && (m_snap[3] == 4'd0);
        steady = (m_mode == 2'd1) || (m_mode == 2'd2);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (!blank) begin
            if (!dark) begin
                e_an = 4'hF;
                e_an[idx] = 1'b0;
                e_seg = seg_of(m_snap[idx]);
            end
            if (idx == 2) e_dp = steady ? 1'b0 : !phase;
            else if (idx == 0 && m_mode == 2'd2) e_dp = 1'b0;
        end
        if ((m_k % FRAME) == FRAME - 1) begin
            m_snap[0] = bus.Minutes_LSB;
            m_snap[1] = bus.Minutes_MSB;
            m_snap[2] = bus.Hours_LSB;
            m_snap[3] = bus.Hours_MSB;
            m_mode    = bus.Mode;
        end
        m_k++;
    endtask

    task automatic random_digit();
        case ($urandom_range(3))
            0: bus.Minutes_LSB = 4'($urandom_range(15));
            1: bus.Minutes_MSB = 4'($urandom_range(15));
            2: bus.Hours_LSB   = 4'($urandom_range(15));
            default: bus.Hours_MSB = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
        endcase
    endtask

    task automatic run(input int n, input int dig_pct, input int mode_pct, input int alarm_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("AN", 32'(bus.AN), 32'(e_an));
            check("SEG", 32'(bus.SEG), 32'(e_seg));
            check("DP", 32'(bus.DP), 32'(e_dp));
            if (int'($urandom_range(99)) < dig_pct) random_digit();
            if (int'($urandom_range(99)) < mode_pct) bus.Mode = 2'($urandom_range(3));
            if (int'($urandom_range(99)) < alarm_pct) bus.ALARM = ~bus.ALARM;
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_AN"}, 32'(bus.AN), 32'h0F);
        check({tag, "_SEG"}, 32'(bus.SEG), 32'h7F);
        check({tag, "_DP"}, 32'(bus.DP), 32'h1);
    endtask

    initial begin
        clr_n           = 1'b0;
        bus.Hours_MSB   = 4'd1;
        bus.Hours_LSB   = 4'd2;
        bus.Minutes_MSB = 4'd3;
        bus.Minutes_LSB = 4'd4;
        bus.Mode        = 2'd0;
        bus.ALARM       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_blank("reset");
        clr_n = 1'b1;

        // Steady 1,2,3,4 in clock mode: colon blinks every two frames.
        run(5 * FRAME * BF, 0, 0, 0);
        // Armed mode: colon and armed dot lit every frame.
        bus.Mode = 2'd2;
        run(4 * FRAME, 0, 0, 0);
        // Alarm-set mode with digits changing mid-frame, including dashes and dark tens.
        bus.Mode = 2'd1;
        run(12 * FRAME, 15, 0, 0);
        // Alarm flash over several blink periods, then release.
        bus.Mode  = 2'd0;
        bus.ALARM = 1'b1;
        run(12 * FRAME, 5, 0, 0);
        bus.ALARM = 1'b0;
        run(6 * FRAME, 5, 0, 0);
        // Everything random.
        run(60 * FRAME, 10, 3, 2);

        // Reset pulse mid-slot blanks the pins without waiting for a clock edge.
        bus.Hours_MSB = 4'd2;
        bus.ALARM     = 1'b0;
        run(FRAME + 2, 0, 0, 0);
        #2;
        clr_n = 1'b0;
        #1;
        check_blank("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_blank("held_rst");
        clr_n = 1'b1;
        model_reset();
        run(8 * FRAME, 10, 2, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
